// File: rtl/writeback_if.sv
// Handshake and result bundle between the memory stage, data memory, the register file
// and the writeback stage. The slave modport is the writeback stage's view.
interface writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        retire;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_err;

  modport slave (
    input  in_valid, in_kind, in_rd, in_funct3, in_result, dmem_rvalid, dmem_rdata,
    output in_ready, wen, waddr, wdata, retire, pend_valid, pend_rd, load_err
  );

  modport master (
    output in_valid, in_kind, in_rd, in_funct3, in_result, dmem_rvalid, dmem_rdata,
    input  in_ready, wen, waddr, wdata, retire, pend_valid, pend_rd, load_err
  );
endinterface

// File: rtl/writeback.sv
// rv32 writeback stage: retires ALU ops in one cycle and waits for load data.
// It then aligns and extends the load data before driving the register file write port.
module writeback #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        resetn,
  writeback_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {K_NONE = 2'b00, K_ALU = 2'b01, K_LOAD = 2'b10, K_RSVD = 2'b11} kind_t;

  localparam int             CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             TO_EN = (TIMEOUT > 0);

  state_t        r_state;
  logic [4:0]    r_rd;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lane;
  logic [CW-1:0] r_cnt;
  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic          r_retire;
  logic          r_pend_valid;
  logic          r_load_err;

  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;

  assign w_byte = bus.dmem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = bus.dmem_rdata[{r_lane[1], 4'b0000} +: 16];

  // NOTE: always_comb assigns a default first so no path can leave the output unassigned (no latch).
  always_comb begin
    w_load_data = bus.dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = bus.dmem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_lane       <= '0;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_retire     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_wen      <= 1'b0;
      r_retire   <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            case (kind_t'(bus.in_kind))
              K_ALU: begin
                r_wen    <= (bus.in_rd != 5'd0);
                r_waddr  <= bus.in_rd;
                r_wdata  <= bus.in_result;
                r_retire <= 1'b1;
              end
              K_LOAD: begin
                r_rd         <= bus.in_rd;
                r_funct3     <= bus.in_funct3;
                r_lane       <= bus.in_result[1:0];
                r_cnt        <= '0;
                r_pend_valid <= (bus.in_rd != 5'd0);
                r_state      <= S_WAIT;
              end
              default: r_retire <= 1'b1;
            endcase
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus.dmem_rvalid) begin
            r_wen        <= (r_rd != 5'd0);
            r_waddr      <= r_rd;
            r_wdata      <= w_load_data;
            r_retire     <= 1'b1;
            r_pend_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else if (TO_EN && (r_cnt == LAST)) begin
            // Abandon the load; a response arriving later finds the stage in IDLE and is dropped.
            r_load_err   <= 1'b1;
            r_pend_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.wen        = r_wen;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.retire     = r_retire;
  assign bus.pend_valid = r_pend_valid;
  assign bus.pend_rd    = r_rd;
  assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: table of single ops with hand-computed results,
// plus sequences for pulse width, load timeout and reset during an outstanding load.
module tb_writeback;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  writeback_if bus();

  writeback #(.TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] result;
    int          delay;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] kind, logic [4:0] rd, logic [2:0] funct3,
                              logic [31:0] result, int delay, logic [31:0] rdata,
                              logic exp_wen, logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.kind = kind; v.rd = rd; v.funct3 = funct3; v.result = result;
    v.delay = delay; v.rdata = rdata; v.exp_wen = exp_wen; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge; the op is presented for exactly one posedge.
  task automatic run_vec(input vec_t v);
    check({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_kind   = v.kind;
    bus.in_rd     = v.rd;
    bus.in_funct3 = v.funct3;
    bus.in_result = v.result;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (v.kind == 2'b10) begin
      for (int k = 1; k <= v.delay; k++) begin
        check({v.name, "_pend_valid"}, 32'(bus.pend_valid), 32'(v.rd != 5'd0));
        check({v.name, "_pend_rd"}, 32'(bus.pend_rd), 32'(v.rd));
        check({v.name, "_wait_ready"}, 32'(bus.in_ready), 32'd0);
        if (k == v.delay) begin
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata  = v.rdata;
        end
        @(negedge clk);
      end
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'h0;
    end
    check({v.name, "_wen"}, 32'(bus.wen), 32'(v.exp_wen));
    check({v.name, "_retire"}, 32'(bus.retire), 32'd1);
    check({v.name, "_load_err"}, 32'(bus.load_err), 32'd0);
    check({v.name, "_pend_after"}, 32'(bus.pend_valid), 32'd0);
    if (v.exp_wen) begin
      check({v.name, "_waddr"}, 32'(bus.waddr), 32'(v.rd));
      check({v.name, "_wdata"}, bus.wdata, v.exp_wdata);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_kind     = 2'b00;
    bus.in_rd       = 5'd0;
    bus.in_funct3   = 3'd0;
    bus.in_result   = 32'h0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    resetn          = 1'b0;

    vecs.push_back(mk("alu_rd5",      2'b01, 5'd5,  3'b000, 32'hDEADBEEF, 0, 32'h0,        1'b1, 32'hDEADBEEF));
    vecs.push_back(mk("alu_rd0",      2'b01, 5'd0,  3'b000, 32'h12345678, 0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk("lb_lane3",     2'b10, 5'd7,  3'b000, 32'h00001003, 3, 32'h80FF0000, 1'b1, 32'hFFFFFF80));
    vecs.push_back(mk("lbu_lane3",    2'b10, 5'd7,  3'b100, 32'h00001003, 3, 32'h80FF0000, 1'b1, 32'h00000080));
    vecs.push_back(mk("lh_hi",        2'b10, 5'd9,  3'b001, 32'h00002002, 1, 32'h80011234, 1'b1, 32'hFFFF8001));
    vecs.push_back(mk("lhu_hi",       2'b10, 5'd9,  3'b101, 32'h00002002, 2, 32'h80011234, 1'b1, 32'h00008001));
    vecs.push_back(mk("lw",           2'b10, 5'd9,  3'b010, 32'h00002000, 1, 32'h80011234, 1'b1, 32'h80011234));
    vecs.push_back(mk("lh_lo",        2'b10, 5'd11, 3'b001, 32'h00002000, 1, 32'h80011234, 1'b1, 32'h00001234));
    vecs.push_back(mk("lb_lane1",     2'b10, 5'd13, 3'b000, 32'h00002001, 2, 32'h0000AB00, 1'b1, 32'hFFFFFFAB));
    vecs.push_back(mk("lbu_lane2",    2'b10, 5'd14, 3'b100, 32'h00002002, 1, 32'h00CD0000, 1'b1, 32'h000000CD));
    vecs.push_back(mk("lb_lane0_pos", 2'b10, 5'd15, 3'b000, 32'h00002000, 1, 32'hFFFFFF7F, 1'b1, 32'h0000007F));
    vecs.push_back(mk("f3_011_word",  2'b10, 5'd16, 3'b011, 32'h00002001, 1, 32'hA5A55A5A, 1'b1, 32'hA5A55A5A));
    vecs.push_back(mk("f3_110_word",  2'b10, 5'd17, 3'b110, 32'h00002003, 2, 32'h0F0F00FF, 1'b1, 32'h0F0F00FF));
    vecs.push_back(mk("load_rd0",     2'b10, 5'd0,  3'b010, 32'h00002000, 2, 32'hFFFFFFFF, 1'b0, 32'h0));
    vecs.push_back(mk("kind_none",    2'b00, 5'd20, 3'b000, 32'h11111111, 0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk("kind_rsvd",    2'b11, 5'd21, 3'b000, 32'h22222222, 0, 32'h0,        1'b0, 32'h0));

    // Reset state, sampled while reset is held.
    #12;
    check("rst_wen",        32'(bus.wen),        32'd0);
    check("rst_retire",     32'(bus.retire),     32'd0);
    check("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
    check("rst_load_err",   32'(bus.load_err),   32'd0);
    check("rst_waddr",      32'(bus.waddr),      32'd0);
    check("rst_wdata",      bus.wdata,           32'd0);
    check("rst_pend_rd",    32'(bus.pend_rd),    32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Ops back to back: each new op is presented in the write cycle of the previous one.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Single-cycle pulses with held write port.
    run_vec(mk("alu_rd12", 2'b01, 5'd12, 3'b000, 32'hCAFEF00D, 0, 32'h0, 1'b1, 32'hCAFEF00D));
    @(negedge clk);
    check("pulse_wen_low",    32'(bus.wen),    32'd0);
    check("pulse_retire_low", 32'(bus.retire), 32'd0);
    check("hold_waddr",       32'(bus.waddr),  32'd12);
    check("hold_wdata",       bus.wdata,       32'hCAFEF00D);

    // Load with no response: abandoned after TIMEOUT WAIT cycles.
    bus.in_valid = 1'b1; bus.in_kind = 2'b10; bus.in_rd = 5'd3; bus.in_funct3 = 3'b010;
    bus.in_result = 32'h00003000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      check("to_wait_load_err", 32'(bus.load_err),   32'd0);
      check("to_wait_pend",     32'(bus.pend_valid), 32'd1);
      check("to_wait_ready",    32'(bus.in_ready),   32'd0);
      @(negedge clk);
    end
    check("to_load_err",  32'(bus.load_err),   32'd1);
    check("to_wen",       32'(bus.wen),        32'd0);
    check("to_retire",    32'(bus.retire),     32'd0);
    check("to_pend_drop", 32'(bus.pend_valid), 32'd0);
    check("to_in_ready",  32'(bus.in_ready),   32'd1);
    check("to_wdata_hold", bus.wdata,          32'hCAFEF00D);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h99999999;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    check("late_rvalid_wen",    32'(bus.wen),      32'd0);
    check("late_rvalid_retire", 32'(bus.retire),   32'd0);
    check("late_load_err_low",  32'(bus.load_err), 32'd0);
    check("late_in_ready",      32'(bus.in_ready), 32'd1);

    // Asynchronous reset in the middle of an outstanding load.
    bus.in_valid = 1'b1; bus.in_kind = 2'b10; bus.in_rd = 5'd10; bus.in_funct3 = 3'b010;
    bus.in_result = 32'h00004000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mr_pend_valid", 32'(bus.pend_valid), 32'd1);
    check("mr_pend_rd",    32'(bus.pend_rd),    32'd10);
    #2 resetn = 1'b0;
    #1;
    check("mr_async_pend",  32'(bus.pend_valid), 32'd0);
    check("mr_async_ready", 32'(bus.in_ready),   32'd1);
    check("mr_async_waddr", 32'(bus.waddr),      32'd0);
    check("mr_async_wdata", bus.wdata,           32'd0);
    check("mr_async_pdrd",  32'(bus.pend_rd),    32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h77777777;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    check("post_rst_wen",      32'(bus.wen),      32'd0);
    check("post_rst_retire",   32'(bus.retire),   32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
